// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic units.
// Holds the sequencer state encoding and the 1-bit full-subtract equation.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result packed as {borrow_out, difference}.
  function automatic logic [1:0] full_sub(
    input logic x,
    input logic y,
    input logic bi
  );
    logic d;
    logic bo;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, d};
  endfunction

endpackage

// File: rtl/bitserial_sub_subbit.sv
// Combinational 1-bit full subtractor cell.
// Port order follows the full-adder cell: (x, y, bi) -> (d, bo).
module subbit
  import serial_arith_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign {bo, d} = full_sub(x, y, bi);

endmodule

// File: rtl/bitserial_sub.sv
// Bit-serial subtractor: a - b - bin, LSB first, one bit per cycle.
// Accept, WIDTH shift cycles, then hold the result until it is taken.
module bitserial_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic cell_d;
  logic cell_bo;

  subbit u_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
        brw_d  = cell_bo;
        // Published borrow only moves with the final bit.
        if (cnt_q == LAST) begin
          bout_d  = cell_bo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = res_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_bitserial_sub.sv
// Scoreboard bench for bitserial_sub at WIDTH=8 and WIDTH=1.
// Directed vectors push expected {bout,diff}; monitors pop on handshake.
module tb_bitserial_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8, b8, diff8;
  logic       bin8, bout8;

  logic in_valid1, in_ready1, out_valid1, out_ready1;
  logic a1, b1, diff1;
  logic bin1, bout1;

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  bitserial_sub #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .bin       (bin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .diff      (diff8),
    .bout      (bout8)
  );

  bitserial_sub #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .diff      (diff1),
    .bout      (bout1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        chk("res8_unexpected", 1, 0);
      end else begin
        chk("res8", int'({bout8, diff8}), int'(q8.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        chk("res1_unexpected", 1, 0);
      end else begin
        chk("res1", int'({bout1, diff1}), int'(q1.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8();
    int n = 0;
    while (!in_ready8 && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready8_wait", int'(in_ready8), 1);
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b,
                         input logic bin);
    wait_ready8();
    a8 = a;
    b8 = b;
    bin8 = bin;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input logic [8:0] exp);
    int lat;
    q8.push_back(exp);
    out_ready8 = 1'b1;
    accept8(a, b, bin);
    wait_valid8(lat);
    chk("latency8", lat, 8);
    tick();
    chk("in_ready8_after", int'(in_ready8), 1);
  endtask

  task automatic run1(input logic a, input logic b, input logic bin,
                      input logic [1:0] exp);
    int lat = 0;
    q1.push_back(exp);
    out_ready1 = 1'b1;
    chk("in_ready1", int'(in_ready1), 1);
    a1 = a;
    b1 = b;
    bin1 = bin;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    while (!out_valid1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency1", lat, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    a8 = '0;
    b8 = '0;
    bin8 = 1'b0;
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    a1 = 1'b0;
    b1 = 1'b0;
    bin1 = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", int'(out_valid8), 0);
    chk("rst_diff", int'(diff8), 0);
    chk("rst_bout", int'(bout8), 0);
    chk("rst_in_ready", int'(in_ready8), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready8), 1);

    run8(8'h5A, 8'h23, 1'b0, {1'b0, 8'h37});
    run8(8'h10, 8'h20, 1'b0, {1'b1, 8'hF0});
    run8(8'h00, 8'h00, 1'b1, {1'b1, 8'hFF});

    // Backpressure
    q8.push_back({1'b0, 8'hFE});
    out_ready8 = 1'b0;
    accept8(8'hFF, 8'h01, 1'b0);
    wait_valid8(lat);
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(out_valid8), 1);
      chk("bp_diff", int'(diff8), 'hFE);
      chk("bp_bout", int'(bout8), 0);
      chk("bp_in_ready", int'(in_ready8), 0);
      tick();
    end
    out_ready8 = 1'b1;
    tick();
    chk("bp_in_ready_after", int'(in_ready8), 1);
    chk("bp_valid_after", int'(out_valid8), 0);

    // Reset at the 4th RUN cycle discards the operation
    accept8(8'h5A, 8'h23, 1'b0);
    repeat (3) tick();
    chk("mid_run_valid", int'(out_valid8), 0);
    rst_n = 1'b0;
    tick();
    chk("mrst_out_valid", int'(out_valid8), 0);
    chk("mrst_diff", int'(diff8), 0);
    chk("mrst_bout", int'(bout8), 0);
    chk("mrst_in_ready", int'(in_ready8), 0);
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready_hi", int'(in_ready8), 1);
    run8(8'h80, 8'h7F, 1'b0, {1'b0, 8'h01});

    // in_valid held with fresh operands during RUN/DONE is ignored
    q8.push_back({1'b0, 8'h22});
    out_ready8 = 1'b0;
    accept8(8'h33, 8'h11, 1'b0);
    in_valid8 = 1'b1;
    a8 = 8'h99;
    b8 = 8'hAB;
    bin8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("busy_in_ready", int'(in_ready8), 0);
      a8 = a8 + 8'd7;
      tick();
    end
    chk("busy_valid", int'(out_valid8), 1);
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    chk("busy_in_ready_after", int'(in_ready8), 1);

    // WIDTH=1
    run1(1'b0, 1'b1, 1'b0, 2'b11);
    run1(1'b1, 1'b1, 1'b1, 2'b11);
    run1(1'b1, 1'b0, 1'b0, 2'b01);

    repeat (3) tick();
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
